// File: rtl/la_control_pkg.sv
// Shared register map, FSM encoding and CTRL bits for the LA capture controller.
// Snapshot readback is controlled by LA_CTRL_SNAPSHOT_READ_EN.
package la_control_pkg;

  localparam logic [5:0] OFF_SEL    = 6'h00;
  localparam logic [5:0] OFF_CTRL   = 6'h04;
  localparam logic [5:0] OFF_MASK   = 6'h08;
  localparam logic [5:0] OFF_VALUE  = 6'h0C;
  localparam logic [5:0] OFF_POST   = 6'h10;
  localparam logic [5:0] OFF_STATUS = 6'h14;
  localparam logic [5:0] OFF_DATA0  = 6'h20;
  localparam logic [5:0] OFF_DATA1  = 6'h24;
  localparam logic [5:0] OFF_DATA2  = 6'h28;
  localparam logic [5:0] OFF_DATA3  = 6'h2C;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_FREEZE  = 1;
  localparam int CTRL_RELEASE = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } la_state_e;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/la_bank_mux.sv
// One 32-bit LA bank: picks the selected team's slice, zero when out of range.
// Snapshot readback is controlled by LA_CTRL_SNAPSHOT_READ_EN.
module la_bank_mux #(
  parameter int NUM_TEAMS = 1,
  parameter int BANK      = 0
) (
  input  logic [128*NUM_TEAMS-1:0] flat_i,
  input  logic [7:0]               sel_i,
  output logic [31:0]              bank_o
);

  always_comb begin
    bank_o = '0;
    for (int t = 1; t <= NUM_TEAMS; t++)
      if (sel_i == 8'(t))
        bank_o = flat_i[128*(t-1)+32*BANK +: 32];
  end

endmodule

// File: rtl/la_capture_ctrl.sv
// Wishbone LA output selector with trigger/freeze capture sequencer.
// Define LA_CTRL_SNAPSHOT_READ_EN to expose la_data_out at DATA0..DATA3.
module la_capture_ctrl
  import la_control_pkg::*;
#(
  parameter int          NUM_TEAMS = 1,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [128*NUM_TEAMS-1:0] designs_la_data_flat,
  output logic [127:0]             la_data_out,
  output logic                     la_frozen_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] sel_q, sel_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] value_q, value_d;
  logic [15:0] post_q, post_d;
  logic [15:0] cnt_q, cnt_d;
  logic [127:0] la_q, la_d;
  la_state_e   state_q, state_d;

  logic        hit, acc, wr;
  logic [5:0]  off;
  logic        ctrl_wr, arm, frz, rel, match;
  logic [31:0] rdata;
  logic [127:0] live;

  for (genvar i = 0; i < 4; i++) begin : g_bank
    la_bank_mux #(
      .NUM_TEAMS(NUM_TEAMS),
      .BANK     (i)
    ) u_bank (
      .flat_i(designs_la_data_flat),
      .sel_i (sel_q[8*i +: 8]),
      .bank_o(live[32*i +: 32])
    );
  end

  assign off = wbs_adr_i[5:0];
  assign hit = wbs_cyc_i & wbs_stb_i &
               (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
  assign acc = hit & ~ack_q;
  assign wr  = acc & wbs_we_i;

  assign ctrl_wr = wr & (off == OFF_CTRL) & wbs_sel_i[0];
  assign arm = ctrl_wr & wbs_dat_i[CTRL_ARM];
  assign frz = ctrl_wr & wbs_dat_i[CTRL_FREEZE];
  assign rel = ctrl_wr & wbs_dat_i[CTRL_RELEASE];

  assign match = ((la_q[31:0] ^ value_q) & mask_q) == 32'h0;

  always_comb begin
    sel_d   = sel_q;
    mask_d  = mask_q;
    value_d = value_q;
    post_d  = post_q;
    if (wr) begin
      unique case (off)
        OFF_SEL:   sel_d   = byte_merge(sel_q, wbs_dat_i, wbs_sel_i);
        OFF_MASK:  mask_d  = byte_merge(mask_q, wbs_dat_i, wbs_sel_i);
        OFF_VALUE: value_d = byte_merge(value_q, wbs_dat_i, wbs_sel_i);
        OFF_POST:  post_d  = byte_merge({16'h0, post_q},
                                        wbs_dat_i, wbs_sel_i) >> 0;
        default: ;
      endcase
    end
  end

  // CTRL commands take priority over any trigger match in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rel) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (frz) begin
      state_d = ST_FROZEN;
      cnt_d   = '0;
    end else if (arm) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (match) begin
            if (post_q == 16'h0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d = ST_POST;
              cnt_d   = post_q;
            end
          end
        end
        ST_POST: begin
          cnt_d = cnt_q - 16'h1;
          if (cnt_q == 16'h1) state_d = ST_FROZEN;
        end
        default: ;
      endcase
    end
  end

  // Gate on the next state so the sample present at the freeze edge is held
  assign la_d = (state_d == ST_FROZEN) ? la_q : live;

  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_SEL:    rdata = sel_q;
      OFF_MASK:   rdata = mask_q;
      OFF_VALUE:  rdata = value_q;
      OFF_POST:   rdata = {16'h0, post_q};
      OFF_STATUS: rdata = {cnt_q, 14'h0, state_q};
`ifdef LA_CTRL_SNAPSHOT_READ_EN
      OFF_DATA0:  rdata = la_q[31:0];
      OFF_DATA1:  rdata = la_q[63:32];
      OFF_DATA2:  rdata = la_q[95:64];
      OFF_DATA3:  rdata = la_q[127:96];
`endif
      default:    rdata = '0;
    endcase
  end

  assign ack_d = acc;
  assign dat_d = (acc & ~wbs_we_i) ? rdata : 32'h0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      value_q <= '0;
      post_q  <= '0;
      cnt_q   <= '0;
      la_q    <= '0;
      state_q <= ST_IDLE;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      post_q  <= post_d;
      cnt_q   <= cnt_d;
      la_q    <= la_d;
      state_q <= state_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign la_data_out = la_q;
  assign la_frozen_o = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl with two teams and a counter lane.
// Checks snapshot readback both with and without LA_CTRL_SNAPSHOT_READ_EN.
module tb_la_capture_ctrl;

  localparam int          NT   = 2;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic         clk;
  logic         nrst;
  logic         wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_dat_i, wbs_adr_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [128*NT-1:0] flat;
  logic [127:0] la_data_out;
  logic         la_frozen_o;

  logic [31:0]  cnt;
  logic         cnt_en;
  int           checks, errors;

  la_capture_ctrl #(
    .NUM_TEAMS(NT),
    .BASE_ADDR(BASE)
  ) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .wbs_stb_i           (wbs_stb_i),
    .wbs_cyc_i           (wbs_cyc_i),
    .wbs_we_i            (wbs_we_i),
    .wbs_sel_i           (wbs_sel_i),
    .wbs_dat_i           (wbs_dat_i),
    .wbs_adr_i           (wbs_adr_i),
    .wbs_ack_o           (wbs_ack_o),
    .wbs_dat_o           (wbs_dat_o),
    .designs_la_data_flat(flat),
    .la_data_out         (la_data_out),
    .la_frozen_o         (la_frozen_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (cnt_en) cnt <= cnt + 32'd1;

  assign flat[127:0]   = {4{32'hA5A5_A5A5}};
  assign flat[255:128] = {{3{32'h3C3C_3C3C}},
                          cnt_en ? cnt : 32'h3C3C_3C3C};

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] adr,
                         input logic we,
                         input logic [31:0] wd,
                         input logic [3:0] sel,
                         output logic [31:0] rd);
    int n;
    logic got;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = wd;
    wbs_sel_i = sel;
    n = 0;
    got = 1'b0;
    while (!got && n < 4) begin
      @(posedge clk); #1;
      n++;
      if (wbs_ack_o) got = 1'b1;
    end
    check("ack_lat", 128'(n), 128'd1);
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wr32(input logic [5:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(BASE | 32'(off), 1'b1, d, 4'hF, dummy);
  endtask

  task automatic rd32(input logic [5:0] off, output logic [31:0] d);
    wb_xfer(BASE | 32'(off), 1'b0, 32'h0, 4'hF, d);
  endtask

  task automatic wait_frozen(input string tag);
    int n;
    n = 0;
    while (!la_frozen_o && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 128'(la_frozen_o), 128'd1);
  endtask

  logic [31:0] r;

  initial begin
    checks = 0;
    errors = 0;
    cnt = 32'h0;
    cnt_en = 1'b0;
    nrst = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_dat_i = 32'h0;
    wbs_adr_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_la", la_data_out, 128'h0);
    check("rst_ack", 128'(wbs_ack_o), 128'd0);
    check("rst_dat", 128'(wbs_dat_o), 128'd0);
    check("rst_frz", 128'(la_frozen_o), 128'd0);
    nrst = 1'b1;

    rd32(6'h00, r);
    check("rst_sel", 128'(r), 128'h0);
    rd32(6'h14, r);
    check("rst_status", 128'(r), 128'h0);

    wr32(6'h00, 32'h0002_0102);
    check("sel_lat0", la_data_out, 128'h0);
    @(posedge clk); #1;
    check("sel_mux", la_data_out,
          {32'h0, 32'h3C3C_3C3C, 32'hA5A5_A5A5, 32'h3C3C_3C3C});
    rd32(6'h00, r);
    check("sel_rd", 128'(r), 128'h0002_0102);

    cnt_en = 1'b1;
    wr32(6'h08, 32'h0000_00FF);
    wr32(6'h0C, 32'h0000_0042);
    wr32(6'h10, 32'h0);
    wr32(6'h04, 32'h1);
    wait_frozen("trig0_frz");
    check("trig0_byte", 128'(la_data_out[7:0]), 128'h42);
    repeat (5) @(posedge clk);
    #1;
    check("trig0_hold", 128'(la_data_out[7:0]), 128'h42);
    rd32(6'h14, r);
    check("trig0_st", 128'(r), 128'h3);

    wr32(6'h04, 32'h4);
    wr32(6'h10, 32'h3);
    wr32(6'h04, 32'h1);
    wait_frozen("trig3_frz");
    check("trig3_byte", 128'(la_data_out[7:0]), 128'h45);
    rd32(6'h14, r);
    check("trig3_st", 128'(r), 128'h3);

    rd32(6'h24, r);
`ifdef LA_CTRL_SNAPSHOT_READ_EN
    check("data1", 128'(r), 128'hA5A5_A5A5);
`else
    check("data1", 128'(r), 128'h0);
`endif
    rd32(6'h18, r);
    check("unmapped", 128'(r), 128'h0);
    rd32(6'h04, r);
    check("ctrl_rd", 128'(r), 128'h0);

    wr32(6'h04, 32'h4);
    check("rel_frz", 128'(la_frozen_o), 128'd0);
    check("rel_live", 128'(la_data_out[31:0]), 128'(cnt - 32'd1));
    rd32(6'h14, r);
    check("rel_st", 128'(r), 128'h0);

    wr32(6'h08, 32'hFFFF_FFFF);
    wr32(6'h0C, 32'hFFFF_FFFF);
    wr32(6'h04, 32'h1);
    rd32(6'h14, r);
    check("armed_st", 128'(r), 128'h1);
    wr32(6'h04, 32'h6);
    rd32(6'h14, r);
    check("relfrz_st", 128'(r), 128'h0);

    wb_xfer(BASE, 1'b1, 32'hFFFF_FFFF, 4'b0010, r);
    rd32(6'h00, r);
    check("byte_wr", 128'(r), 128'h0002_FF02);

    @(posedge clk); #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = BASE + 32'h40;
    begin
      logic seen;
      seen = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        if (wbs_ack_o) seen = 1'b1;
      end
      check("out_win", 128'(seen), 128'd0);
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;

    wr32(6'h04, 32'h2);
    check("force_frz", 128'(la_frozen_o), 128'd1);
    @(posedge clk); #3;
    nrst = 1'b0;
    #1;
    check("async_la", la_data_out, 128'h0);
    check("async_frz", 128'(la_frozen_o), 128'd0);
    #10;
    nrst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
